// File: rtl/cache_nway_pkg.sv
// cache_nway_pkg: word/address widths, onehot FSM states and the IO device field helper.
package cache_nway_pkg;
    localparam int WORD_W = 36;
    localparam int PADDR_W = 20;
    localparam int DEV_W = 4;
    typedef enum logic [4:0] {
        INIT   = 5'b00001,
        FLUSH  = 5'b00010,
        BYPASS = 5'b00100,
        IDLE   = 5'b01000,
        FILL   = 5'b10000
    } state_t;
    function automatic logic [DEV_W-1:0] dev_of(input logic [PADDR_W-1:0] a);
        return a[PADDR_W-1 -: DEV_W];
    endfunction
endpackage

// File: rtl/cache_way.sv
// cache_way: one way's data, tag and valid arrays; reads are combinational at the addressed set.
module cache_way
    import cache_nway_pkg::*;
#(
    parameter int CACHEADDR = 9,
    parameter int LINEADDR = 2,
    parameter int TAG_W = 9
) (
    input  logic                 clk,
    input  logic [CACHEADDR-1:0] set_addr,
    input  logic [LINEADDR-1:0]  idx,
    input  logic                 data_we,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic                 line_we,
    input  logic [TAG_W-1:0]     line_tag,
    input  logic                 line_valid,
    output logic [WORD_W-1:0]    rd_data,
    output logic [TAG_W-1:0]     tag,
    output logic                 valid
);
    logic [WORD_W-1:0] data_mem [2**(CACHEADDR+LINEADDR)];
    logic [TAG_W-1:0] tag_mem [2**CACHEADDR];
    logic [2**CACHEADDR-1:0] valid_mem;
    always_ff @(posedge clk) begin
        if (data_we) data_mem[{set_addr, idx}] <= wr_data;
        if (line_we) begin
            tag_mem[set_addr] <= line_tag;
            valid_mem[set_addr] <= line_valid;
        end
    end
    assign rd_data = data_mem[{set_addr, idx}];
    assign tag = tag_mem[set_addr];
    assign valid = valid_mem[set_addr];
endmodule

// File: rtl/cache_nway.sv
// cache_nway: N-way write-through read cache between PAG and MEM with IO passthrough.
// Defining CACHE_STATS_EN adds read/write hit/miss counter outputs.
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int WAYS = 4,
    parameter int CACHEADDR = 9,
    parameter int LINEADDR = 2,
    parameter bit ENABLE = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PADDR_W-1:0] pag_addr,
    input  logic [WORD_W-1:0]  pag_write_data,
    output logic [WORD_W-1:0]  pag_read_data,
    input  logic               pag_read,
    input  logic               pag_write,
    input  logic               pag_io_read,
    input  logic               pag_io_write,
    output logic               pag_read_ack,
    output logic               pag_write_ack,
    output logic               pag_nxm,
    input  logic               cache_flush,
    output logic [PADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]  mem_write_data,
    input  logic [WORD_W-1:0]  mem_read_data,
    output logic               mem_read,
    output logic               mem_write,
    input  logic               mem_read_ack,
    input  logic               mem_write_ack,
    input  logic               mem_nxm,
    output logic [DEV_W-1:0]   io_dev,
    output logic [WORD_W-1:0]  io_write_data,
    input  logic [WORD_W-1:0]  io_read_data,
    output logic               io_read,
    output logic               io_write,
    input  logic               io_nxm,
    input  logic [1:7]         io_pi_in,
    output logic [1:7]         pag_pi_out
`ifdef CACHE_STATS_EN
    ,
    output logic [WORD_W-1:0]  stat_read_hit,
    output logic [WORD_W-1:0]  stat_read_miss,
    output logic [WORD_W-1:0]  stat_write_hit,
    output logic [WORD_W-1:0]  stat_write_miss
`endif
);
    localparam int TAG_W = PADDR_W - CACHEADDR - LINEADDR;
    localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
    state_t state;
    logic [CACHEADDR-1:0] flush_cnt;
    logic [PADDR_W-LINEADDR-1:0] fill_line;
    logic [LINEADDR-1:0] beat;
    logic [WAY_W-1:0] victim, new_victim;
    logic use_rr, flush_pend;
    logic [WAY_W-1:0] rr [2**CACHEADDR];
    logic idle, filling, flushing, pass, hit, rd_hit, rd_miss, wr_ok;
    logic fill_ack, fill_done, fill_abort;
    logic [TAG_W-1:0] pag_tag, fill_tag;
    logic [CACHEADDR-1:0] fill_set, lk_set;
    logic [LINEADDR-1:0] lk_idx;
    logic [WORD_W-1:0] wr_word, hit_data;
    logic [WAYS-1:0] way_valid, way_hit;
    logic [WORD_W-1:0] way_data [WAYS];
    logic [TAG_W-1:0] way_tag [WAYS];
    assign idle = state == IDLE;
    assign filling = state == FILL;
    assign flushing = state == FLUSH;
    assign pass = !idle && !filling;
    assign pag_tag = pag_addr[PADDR_W-1 -: TAG_W];
    assign fill_tag = fill_line[PADDR_W-LINEADDR-1 -: TAG_W];
    assign fill_set = fill_line[CACHEADDR-1:0];
    assign lk_set = flushing ? flush_cnt : filling ? fill_set : pag_addr[LINEADDR +: CACHEADDR];
    assign lk_idx = filling ? beat : pag_addr[LINEADDR-1:0];
    assign wr_word = filling ? mem_read_data : pag_write_data;
    assign hit = |way_hit;
    // A simultaneous flush wins over a read, so neither a hit nor a fill starts.
    assign rd_hit = idle && pag_read && !cache_flush && hit;
    assign rd_miss = idle && pag_read && !cache_flush && !hit;
    assign wr_ok = idle && mem_write && mem_write_ack;
    assign fill_ack = filling && mem_read_ack && !mem_nxm;
    assign fill_done = fill_ack && beat == '1;
    assign fill_abort = filling && mem_nxm;
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way #(.CACHEADDR(CACHEADDR), .LINEADDR(LINEADDR), .TAG_W(TAG_W)) u_way (
            .clk       (clk),
            .set_addr  (lk_set),
            .idx       (lk_idx),
            .data_we   (filling ? fill_ack && victim == WAY_W'(w) : wr_ok && way_hit[w]),
            .wr_data   (wr_word),
            .line_we   (flushing || ((fill_done || fill_abort) && victim == WAY_W'(w))),
            .line_tag  (fill_tag),
            .line_valid(fill_done),
            .rd_data   (way_data[w]),
            .tag       (way_tag[w]),
            .valid     (way_valid[w])
        );
        assign way_hit[w] = way_valid[w] && way_tag[w] == pag_tag;
    end
    always_comb begin
        hit_data = '0;
        for (int i = 0; i < WAYS; i++) hit_data |= way_hit[i] ? way_data[i] : '0;
    end
    always_comb begin
        new_victim = rr[lk_set];
        for (int i = WAYS - 1; i >= 0; i--) new_victim = way_valid[i] ? new_victim : WAY_W'(i);
    end
    always_ff @(posedge clk)
        if (flushing) rr[flush_cnt] <= '0;
        else if (fill_done && use_rr)
            rr[fill_set] <= rr[fill_set] == WAY_W'(WAYS - 1) ? '0 : rr[fill_set] + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= INIT;
            flush_cnt <= '1;
            fill_line <= '0;
            beat <= '0;
            victim <= '0;
            use_rr <= 1'b0;
            flush_pend <= 1'b0;
        end else
            case (state)
                INIT: begin
                    state <= FLUSH;
                    flush_cnt <= '1;
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == '0) state <= ENABLE ? IDLE : BYPASS;
                end
                BYPASS, IDLE: begin
                    if (cache_flush) begin
                        state <= FLUSH;
                        flush_cnt <= '1;
                    end else if (rd_miss) begin
                        state <= FILL;
                        fill_line <= pag_addr[PADDR_W-1:LINEADDR];
                        beat <= '0;
                        victim <= new_victim;
                        use_rr <= &way_valid;
                    end
                end
                FILL: begin
                    if (fill_ack) beat <= beat + 1'b1;
                    flush_pend <= (flush_pend || cache_flush) && !(fill_done || fill_abort);
                    if (fill_done || fill_abort) begin
                        state <= flush_pend || cache_flush ? FLUSH : IDLE;
                        flush_cnt <= '1;
                    end
                end
                default: state <= INIT;
            endcase
    assign mem_read = reset_n && (pass ? pag_read : filling);
    assign mem_write = reset_n && !filling && pag_write;
    assign mem_addr = filling ? {fill_line[PADDR_W-LINEADDR-1 -: TAG_W + CACHEADDR], beat} : pag_addr;
    assign mem_write_data = pag_write_data;
    assign pag_read_ack = reset_n && (pass ? mem_read_ack : rd_hit);
    assign pag_write_ack = mem_write && mem_write_ack;
    assign pag_read_data = pag_io_read ? io_read_data : pass ? mem_read_data : hit_data;
    assign pag_nxm = reset_n && (io_nxm || (mem_nxm && (pass || filling || mem_write)));
    assign io_read = reset_n && pag_io_read;
    assign io_write = reset_n && pag_io_write;
    assign io_dev = dev_of(pag_addr);
    assign io_write_data = pag_write_data;
    assign pag_pi_out = io_pi_in;
`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n || state == INIT) begin
            stat_read_hit <= '0;
            stat_read_miss <= '0;
            stat_write_hit <= '0;
            stat_write_miss <= '0;
        end else begin
            stat_read_hit <= stat_read_hit + WORD_W'(rd_hit);
            stat_read_miss <= stat_read_miss + WORD_W'(fill_done);
            stat_write_hit <= stat_write_hit + WORD_W'(wr_ok && hit);
            stat_write_miss <= stat_write_miss + WORD_W'(wr_ok && !hit);
        end
`endif
endmodule

// File: tb/tb_cache_nway.sv
// tb_cache_nway: directed vectors for cache_nway (WAYS=4, CACHEADDR=9, LINEADDR=2, ENABLE=1).
module tb_cache_nway;
    import cache_nway_pkg::*;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [PADDR_W-1:0] pag_addr = '0;
    logic [WORD_W-1:0] pag_write_data = '0, io_read_data = '0;
    logic pag_read = 1'b0, pag_write = 1'b0, pag_io_read = 1'b0, pag_io_write = 1'b0;
    logic cache_flush = 1'b0, io_nxm = 1'b0;
    logic [1:7] io_pi_in = '0;
    logic [WORD_W-1:0] pag_read_data, mem_write_data, mem_read_data, io_write_data;
    logic [PADDR_W-1:0] mem_addr;
    logic [DEV_W-1:0] io_dev;
    logic [1:7] pag_pi_out;
    logic pag_read_ack, pag_write_ack, pag_nxm, mem_read, mem_write;
    logic mem_read_ack, mem_write_ack, mem_nxm, io_read, io_write;
    logic nxm_arm = 1'b0, nxm_fired = 1'b0;
    logic [PADDR_W-1:0] beats [$];
    logic [PADDR_W-1:0] wr_last = '0;
    int wr_cnt = 0, nxm_cnt = 0;
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [WORD_W-1:0] mem_fn(input logic [PADDR_W-1:0] a);
        return {16'hC0DE, a};
    endfunction

    // Memory model: same-cycle acks; optional one-shot nxm on the third beat of a line.
    assign mem_nxm = mem_read && nxm_arm && !nxm_fired && mem_addr[1:0] == 2'd2;
    assign mem_read_ack = mem_read && !mem_nxm;
    assign mem_write_ack = mem_write;
    assign mem_read_data = mem_fn(mem_addr);

    always @(posedge clk) if (mem_nxm) nxm_fired <= 1'b1;

    always @(negedge clk) begin
        if (mem_read && mem_read_ack) beats.push_back(mem_addr);
        if (mem_write && mem_write_ack) begin
            wr_cnt++;
            wr_last = mem_addr;
        end
        if (pag_nxm) nxm_cnt++;
    end

    cache_nway dut (
        .clk(clk), .reset_n(reset_n),
        .pag_addr(pag_addr), .pag_write_data(pag_write_data), .pag_read_data(pag_read_data),
        .pag_read(pag_read), .pag_write(pag_write), .pag_io_read(pag_io_read), .pag_io_write(pag_io_write),
        .pag_read_ack(pag_read_ack), .pag_write_ack(pag_write_ack), .pag_nxm(pag_nxm),
        .cache_flush(cache_flush),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_ack(mem_read_ack),
        .mem_write_ack(mem_write_ack), .mem_nxm(mem_nxm),
        .io_dev(io_dev), .io_write_data(io_write_data), .io_read_data(io_read_data),
        .io_read(io_read), .io_write(io_write), .io_nxm(io_nxm),
        .io_pi_in(io_pi_in), .pag_pi_out(pag_pi_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Holds pag_read until acked (bounded); lat = cycles before the ack cycle.
    task automatic rd(input logic [PADDR_W-1:0] a, output logic [WORD_W-1:0] d, output int lat,
                      output int nb);
        int base;
        base = beats.size();
        pag_addr = a;
        pag_read = 1'b1;
        lat = 0;
        d = '0;
        forever begin
            @(negedge clk);
            if (pag_read_ack) begin
                d = pag_read_data;
                break;
            end
            if (++lat > 40) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        pag_read = 1'b0;
        nb = beats.size() - base;
    endtask

    task automatic wr(input logic [PADDR_W-1:0] a, input logic [WORD_W-1:0] d, output logic ack,
                      output int nw);
        int base;
        base = wr_cnt;
        pag_addr = a;
        pag_write_data = d;
        pag_write = 1'b1;
        @(negedge clk);
        ack = pag_write_ack;
        @(posedge clk);
        #1;
        pag_write = 1'b0;
        nw = wr_cnt - base;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dut.state == IDLE) break;
        end
        check(tag, dut.state, IDLE);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WORD_W-1:0] d;
        logic ack;
        int lat, nb, nw, fc, nx0;
        logic [PADDR_W-1:0] lines [5];
        io_pi_in = 7'b1011001;
        pag_read = 1'b1;
        pag_addr = 20'o1000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_read_ack", pag_read_ack, 1'b0);
        check("rst_state", dut.state, INIT);
        check("pi_passthrough", pag_pi_out, 7'b1011001);
        pag_read = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        fc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dut.state == FLUSH) fc++;
            if (dut.state == IDLE) break;
        end
        check("flush_cycles", fc, 512);
        check("idle_after_flush", dut.state, IDLE);
        @(posedge clk);
        #1;

        rd(20'o1000, d, lat, nb);
        check("miss_latency", lat, 5);
        check("miss_beats", nb, 4);
        for (int i = 0; i < 4; i++) check("fill_beat_addr", beats[beats.size() - 4 + i], 20'o1000 + i);
        check("miss_data", d, mem_fn(20'o1000));
        rd(20'o1002, d, lat, nb);
        check("hit_latency", lat, 0);
        check("hit_no_mem", nb, 0);
        check("hit_data", d, mem_fn(20'o1002));

        wr(20'o1001, 36'o123, ack, nw);
        check("whit_ack", ack, 1'b1);
        check("whit_mem_write", nw, 1);
        check("whit_addr", wr_last, 20'o1001);
        rd(20'o1001, d, lat, nb);
        check("whit_read_latency", lat, 0);
        check("whit_read_data", d, 36'o123);
        wr(20'o7000, 36'o456, ack, nw);
        check("wmiss_mem_write", nw, 1);
        rd(20'o7000, d, lat, nb);
        check("wmiss_read_latency", lat, 5);
        check("wmiss_read_data", d, mem_fn(20'o7000));

        for (int k = 0; k < 5; k++) lines[k] = PADDR_W'((k + 1) * 'o10000);
        for (int k = 0; k < 5; k++) begin
            rd(lines[k], d, lat, nb);
            check("set0_fill_latency", lat, 5);
        end
        rd(lines[1], d, lat, nb);
        check("line2_still_hits", lat, 0);
        rd(lines[0], d, lat, nb);
        check("line1_evicted", lat, 5);
        rd(lines[2], d, lat, nb);
        check("line3_still_hits", lat, 0);
        rd(lines[1], d, lat, nb);
        check("rr_evicts_way1", lat, 5);
        check("rr_refill_data", d, mem_fn(lines[1]));

        nxm_arm = 1'b1;
        nx0 = nxm_cnt;
        rd(20'o2000, d, lat, nb);
        nxm_arm = 1'b0;
        check("nxm_pulses", nxm_cnt - nx0, 1);
        check("nxm_retry_latency", lat, 9);
        check("nxm_total_beats", nb, 6);
        check("nxm_refill_from_0", beats[beats.size() - 4], 20'o2000);
        check("nxm_retry_data", d, mem_fn(20'o2000));

        fork
            rd(20'o3000, d, lat, nb);
            begin
                repeat (2) @(posedge clk);
                #1 cache_flush = 1'b1;
                @(posedge clk);
                #1 cache_flush = 1'b0;
            end
        join
        check("flush_in_fill_latency", lat, 5);
        check("flush_in_fill_beats", nb, 5);
        check("flush_in_fill_data", d, mem_fn(20'o3000));
        check("flush_after_fill", dut.state, FLUSH);
        wait_idle("idle_after_late_flush");
        rd(20'o1000, d, lat, nb);
        check("prior_hit_misses", lat, 5);

        pag_io_read = 1'b1;
        pag_addr = 20'hA1234;
        io_read_data = 36'h5_5555_5555;
        io_nxm = 1'b1;
        @(negedge clk);
        check("io_read", io_read, 1'b1);
        check("io_dev", io_dev, 4'hA);
        check("io_read_data", pag_read_data, 36'h5_5555_5555);
        check("io_nxm", pag_nxm, 1'b1);
        check("io_no_mem_read", mem_read, 1'b0);
        @(posedge clk);
        #1;
        pag_io_read = 1'b0;
        io_nxm = 1'b0;
        pag_io_write = 1'b1;
        @(negedge clk);
        check("io_write", io_write, 1'b1);
        check("io_no_mem_write", mem_write, 1'b0);
        @(posedge clk);
        #1 pag_io_write = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
